// File: rtl/mul_share_pkg.sv
// Shared parameters and tag type for the multiplier-sharing arbiter.
package mul_share_pkg;
    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 8;
    localparam int LAT_DEF    = 4;
    localparam int MAXOUT_DEF = 4;
    localparam int IDW        = $clog2(NREQ_DEF);
    localparam int CW         = $clog2(MAXOUT_DEF + 1);

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gid
);
    logic found;

    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found                           = 1'b1;
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                gid                             = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/mul_share_arb.sv
// Shares one fixed-latency pipelined multiplier among NREQ requesters with
// round-robin grant, per-requester credit limits and a tag pipeline for routing.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int W      = W_DEF,
    parameter int LAT    = LAT_DEF,
    parameter int MAXOUT = MAXOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_data,
    output logic              mul_en_in,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_en_out,
    input  logic [2*W-1:0]    mul_out,
    output logic              busy,
    output logic              err
);
    localparam int CWL = $clog2(MAXOUT + 1);

    logic [IDW-1:0]  rr_ptr;
    logic [CWL-1:0]  outst [NREQ];
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    tag_t            tags [LAT];
    tag_t            tail;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] && (outst[i] < CWL'(MAXOUT));
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant),
        .gid   (gid)
    );

    // Outputs are held low for the whole reset assertion, not just after it.
    assign req_ready = grant & {NREQ{~rst}};
    assign mul_en_in = |req_ready;
    assign tail      = tags[LAT-1];

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                mul_a = req_a[i*W +: W];
                mul_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tail.v && mul_en_out) begin
            rsp_valid[tail.id] = 1'b1;
            rsp_data           = mul_out;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < LAT; s++)
            busy = busy | tags[s].v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            err    <= 1'b0;
            for (int s = 0; s < LAT; s++) tags[s] <= '0;
            for (int i = 0; i < NREQ; i++) outst[i] <= '0;
        end else begin
            if (mul_en_in)
                rr_ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            tags[0] <= '{v: mul_en_in, id: gid};
            for (int s = 1; s < LAT; s++) tags[s] <= tags[s-1];
            if (tail.v != mul_en_out)
                err <= 1'b1;
            // Credit is returned on tail.v alone so a missing strobe cannot deadlock.
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && !(tail.v && tail.id == IDW'(i)))
                    outst[i] <= outst[i] + 1'b1;
                else if (!req_ready[i] && tail.v && tail.id == IDW'(i) && outst[i] != '0)
                    outst[i] <= outst[i] - 1'b1;
            end
        end
    end
endmodule
